// File: rtl/gencon_pkg.sv
// Shared types and constants for the gencon calculator controller: FSM states, keypad codes,
// the operand limit and the decimal-accumulate helper.
package gencon_pkg;

    typedef enum logic [2:0] {
        GET_FIRST_NUM,
        GET_SECOND_NUM,
        WAIT_ALU,
        WRITE_MEM,
        READ_MEM,
        DONE
    } gencon_state_e;

    localparam logic [3:0] KEY_NONE = 4'h0;
    localparam logic [3:0] KEY_ZERO = 4'hA;
    localparam logic [3:0] KEY_NEG  = 4'hB;

    localparam int unsigned MAX_OPERAND = 32767;

    // Returns {accepted, new_operand}; the magnitude grows by one decimal digit, sign is kept.
    function automatic logic [16:0] acc_digit(input logic [15:0] operand,
                                              input logic [3:0]  digit);
        logic [15:0] mag;
        logic [19:0] prod;
        logic [15:0] neg_prod;
        mag      = operand[15] ? 16'(-operand) : operand;
        prod     = {4'b0, mag} * 20'd10 + {16'b0, digit};
        neg_prod = 16'(-prod[15:0]);
        if (prod <= 20'(MAX_OPERAND)) begin
            return {1'b1, operand[15] ? neg_prod : prod[15:0]};
        end
        return {1'b0, operand};
    endfunction

endpackage

// File: rtl/gencon_keypad_dec.sv
// Keypad edge detect and decode: a key counts once when it appears or changes.
// Negate key (0xB) is decoded only when GENCON_NEG_KEY_EN is defined.
module gencon_keypad_dec
    import gencon_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] keypad_input,
    output logic       digit_valid,
    output logic [3:0] digit_value,
    output logic       neg_valid
);

    logic [3:0] key_prev;
    logic       key_new;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_prev <= KEY_NONE;
        end else begin
            key_prev <= keypad_input;
        end
    end

    assign key_new = (keypad_input != KEY_NONE) && (keypad_input != key_prev);

    always_comb begin
        digit_valid = key_new && (keypad_input <= KEY_ZERO);
        digit_value = (keypad_input == KEY_ZERO) ? 4'd0 : keypad_input;
`ifdef GENCON_NEG_KEY_EN
        neg_valid   = key_new && (keypad_input == KEY_NEG);
`else
        neg_valid   = 1'b0;
`endif
    end

endmodule

// File: rtl/gencon.sv
// Calculator controller: collects two operands from a keypad, runs the ALU, stores the result
// in a 16-entry memory and reads it back for display. Optional macro: GENCON_NEG_KEY_EN.
module gencon
    import gencon_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  keypad_input,
    input  logic        operator_input,
    input  logic        equal_input,
    input  logic [15:0] ALU_out,
    input  logic        ALU_finish,
    input  logic [15:0] data,
    output logic [15:0] ALU_in1,
    output logic [15:0] ALU_in2,
    output logic        start_calc,
    output logic [15:0] display_output,
    output logic        complete,
    output logic        we,
    output logic        oe,
    output logic [3:0]  mem_addr,
    output logic [15:0] mem_data
);

    gencon_state_e state;
    logic [15:0]   result;
    logic [3:0]    ptr;
    logic          op_prev;
    logic          eq_prev;
    logic          rd_capture;

    logic          digit_valid;
    logic [3:0]    digit_value;
    logic          neg_valid;
    logic          op_rise;
    logic          eq_rise;
    logic [16:0]   acc1;
    logic [16:0]   acc2;
    logic [15:0]   in1_neg;
    logic [15:0]   in2_neg;

    gencon_keypad_dec u_keypad_dec (
        .clk          (clk),
        .reset        (reset),
        .keypad_input (keypad_input),
        .digit_valid  (digit_valid),
        .digit_value  (digit_value),
        .neg_valid    (neg_valid)
    );

    assign op_rise = operator_input & ~op_prev;
    assign eq_rise = equal_input & ~eq_prev;
    assign acc1    = acc_digit(ALU_in1, digit_value);
    assign acc2    = acc_digit(ALU_in2, digit_value);
    assign in1_neg = -ALU_in1;
    assign in2_neg = -ALU_in2;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= GET_FIRST_NUM;
            ALU_in1        <= '0;
            ALU_in2        <= '0;
            start_calc     <= 1'b0;
            display_output <= '0;
            complete       <= 1'b0;
            we             <= 1'b0;
            oe             <= 1'b0;
            mem_addr       <= '0;
            mem_data       <= '0;
            result         <= '0;
            ptr            <= '0;
            op_prev        <= 1'b0;
            eq_prev        <= 1'b0;
            rd_capture     <= 1'b0;
        end else begin
            op_prev <= operator_input;
            eq_prev <= equal_input;
            case (state)
                GET_FIRST_NUM: begin
                    if (op_rise) begin
                        state          <= GET_SECOND_NUM;
                        ALU_in2        <= '0;
                        display_output <= '0;
                    end else if (digit_valid) begin
                        if (acc1[16]) begin
                            ALU_in1        <= acc1[15:0];
                            display_output <= acc1[15:0];
                        end
                    end else if (neg_valid) begin
                        ALU_in1        <= in1_neg;
                        display_output <= in1_neg;
                    end
                end
                GET_SECOND_NUM: begin
                    if (eq_rise) begin
                        state      <= WAIT_ALU;
                        start_calc <= 1'b1;
                    end else if (digit_valid) begin
                        if (acc2[16]) begin
                            ALU_in2        <= acc2[15:0];
                            display_output <= acc2[15:0];
                        end
                    end else if (neg_valid) begin
                        ALU_in2        <= in2_neg;
                        display_output <= in2_neg;
                    end
                end
                WAIT_ALU: begin
                    // A finish seen alongside the start pulse belongs to an older request.
                    if (start_calc) begin
                        start_calc <= 1'b0;
                    end else if (ALU_finish) begin
                        state    <= WRITE_MEM;
                        result   <= ALU_out;
                        we       <= 1'b1;
                        mem_addr <= ptr;
                        mem_data <= ALU_out;
                    end
                end
                WRITE_MEM: begin
                    state    <= READ_MEM;
                    we       <= 1'b0;
                    oe       <= 1'b1;
                    mem_addr <= ptr;
                end
                READ_MEM: begin
                    state      <= DONE;
                    oe         <= 1'b0;
                    ptr        <= ptr + 4'd1;
                    complete   <= 1'b1;
                    rd_capture <= 1'b1;
                end
                DONE: begin
                    // Read data arrives one cycle after oe, i.e. during the first DONE cycle.
                    rd_capture <= 1'b0;
                    if (rd_capture) begin
                        display_output <= data;
                    end
                    if (op_rise) begin
                        state          <= GET_SECOND_NUM;
                        complete       <= 1'b0;
                        ALU_in1        <= result;
                        ALU_in2        <= '0;
                        display_output <= '0;
                    end else if (digit_valid) begin
                        state          <= GET_FIRST_NUM;
                        complete       <= 1'b0;
                        ALU_in1        <= {12'b0, digit_value};
                        ALU_in2        <= '0;
                        display_output <= {12'b0, digit_value};
                    end
                end
                default: state <= GET_FIRST_NUM;
            endcase
        end
    end

endmodule

// File: tb/tb_gencon.sv
// Directed, table-driven bench for gencon with a small memory model and a scripted ALU.
module tb_gencon;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  keypad_input;
    logic        operator_input;
    logic        equal_input;
    logic [15:0] ALU_out;
    logic        ALU_finish;
    logic [15:0] data;
    logic [15:0] ALU_in1;
    logic [15:0] ALU_in2;
    logic        start_calc;
    logic [15:0] display_output;
    logic        complete;
    logic        we;
    logic        oe;
    logic [3:0]  mem_addr;
    logic [15:0] mem_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] mem [16];

    gencon dut (
        .clk            (clk),
        .reset          (reset),
        .keypad_input   (keypad_input),
        .operator_input (operator_input),
        .equal_input    (equal_input),
        .ALU_out        (ALU_out),
        .ALU_finish     (ALU_finish),
        .data           (data),
        .ALU_in1        (ALU_in1),
        .ALU_in2        (ALU_in2),
        .start_calc     (start_calc),
        .display_output (display_output),
        .complete       (complete),
        .we             (we),
        .oe             (oe),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data)
    );

    always #5 clk = ~clk;

    // Synchronous memory: read data valid the cycle after oe.
    always @(posedge clk) begin
        if (we) mem[mem_addr] <= mem_data;
        if (oe) data <= mem[mem_addr];
    end

    typedef struct {
        string       name;
        string       keys;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] hex2key(input byte c);
        if (c >= "0" && c <= "9") return 4'(c - "0");
        return 4'(c - "A" + 10);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic press(input logic [3:0] key);
        keypad_input = key;
        step();
        keypad_input = 4'h0;
        step();
    endtask

    task automatic press_op();
        operator_input = 1'b1;
        step();
        operator_input = 1'b0;
        step();
    endtask

    task automatic enter_num(input int v);
        int d [5];
        int n = 0;
        if (v == 0) begin
            press(4'hA);
        end else begin
            while (v > 0) begin
                d[n] = v % 10;
                v    = v / 10;
                n++;
            end
            for (int k = n - 1; k >= 0; k--) press((d[k] == 0) ? 4'hA : 4'(d[k]));
        end
    endtask

    // From GET_SECOND_NUM: equals, scripted ALU response, memory write and read-back.
    task automatic finish_calc(input logic [15:0] a, input logic [15:0] b,
                               input logic [3:0] addr);
        logic [15:0] r;
        r = a + b;
        equal_input = 1'b1;
        step();
        equal_input = 1'b0;
        check("start_calc_on", {15'b0, start_calc}, 16'd1);
        check("alu_in1_wait", ALU_in1, a);
        check("alu_in2_wait", ALU_in2, b);
        ALU_finish = 1'b1;
        ALU_out    = 16'hDEAD;
        step();
        ALU_finish = 1'b0;
        check("start_calc_off", {15'b0, start_calc}, 16'd0);
        check("we_early", {15'b0, we}, 16'd0);
        step();
        step();
        check("we_idle", {15'b0, we}, 16'd0);
        ALU_finish = 1'b1;
        ALU_out    = r;
        step();
        ALU_finish = 1'b0;
        ALU_out    = 16'h0;
        check("we_write", {15'b0, we}, 16'd1);
        check("addr_write", {12'b0, mem_addr}, {12'b0, addr});
        check("mem_data", mem_data, r);
        check("alu_in1_hold", ALU_in1, a);
        step();
        check("oe_read", {15'b0, oe}, 16'd1);
        check("we_off", {15'b0, we}, 16'd0);
        check("addr_read", {12'b0, mem_addr}, {12'b0, addr});
        step();
        check("complete_on", {15'b0, complete}, 16'd1);
        check("oe_off", {15'b0, oe}, 16'd0);
        step();
        check("display_result", display_output, r);
        check("complete_hold", {15'b0, complete}, 16'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in1"}, ALU_in1, 16'd0);
        check({tag, "_in2"}, ALU_in2, 16'd0);
        check({tag, "_start"}, {15'b0, start_calc}, 16'd0);
        check({tag, "_disp"}, display_output, 16'd0);
        check({tag, "_complete"}, {15'b0, complete}, 16'd0);
        check({tag, "_we"}, {15'b0, we}, 16'd0);
        check({tag, "_oe"}, {15'b0, oe}, 16'd0);
        check({tag, "_addr"}, {12'b0, mem_addr}, 16'd0);
        check({tag, "_mdata"}, mem_data, 16'd0);
    endtask

    initial begin
        for (int k = 0; k < 16; k++) mem[k] = 16'h0;
        data           = 16'h0;
        reset          = 1'b1;
        keypad_input   = 4'h0;
        operator_input = 1'b0;
        equal_input    = 1'b0;
        ALU_out        = 16'h0;
        ALU_finish     = 1'b0;

        vecs[0] = '{name: "two_digits",   keys: "12",    exp: 16'd12};
        vecs[1] = '{name: "max_operand",  keys: "32767", exp: 16'd32767};
        vecs[2] = '{name: "overflow_rej", keys: "32768", exp: 16'd3276};
        vecs[3] = '{name: "nines",        keys: "99999", exp: 16'd9999};
        vecs[4] = '{name: "leading_zero", keys: "AA5",   exp: 16'd5};
        vecs[5] = '{name: "ignored_keys", keys: "C4FD2", exp: 16'd42};
`ifdef GENCON_NEG_KEY_EN
        vecs[6] = '{name: "negate",       keys: "5B",    exp: 16'hFFFB};
        vecs[7] = '{name: "negate_acc",   keys: "5B3",   exp: 16'hFFCB};
`else
        vecs[6] = '{name: "negate",       keys: "5B",    exp: 16'd5};
        vecs[7] = '{name: "negate_acc",   keys: "5B3",   exp: 16'd53};
`endif

        step();
        step();
        reset = 1'b0;
        check_all_zero("reset");

        for (int i = 0; i < 8; i++) begin
            do_reset();
            for (int j = 0; j < vecs[i].keys.len(); j++) press(hex2key(vecs[i].keys[j]));
            check({vecs[i].name, "_in1"}, ALU_in1, vecs[i].exp);
            check({vecs[i].name, "_disp"}, display_output, vecs[i].exp);
        end

        // Held key counts once; a different key right after counts again.
        do_reset();
        keypad_input = 4'h1;
        step();
        step();
        step();
        keypad_input = 4'h2;
        step();
        keypad_input = 4'h0;
        step();
        check("held_key", ALU_in1, 16'd12);

        // Basic calculation 12 + 34.
        do_reset();
        enter_num(12);
        equal_input = 1'b1;
        step();
        equal_input = 1'b0;
        step();
        check("eq_ignored_first", display_output, 16'd12);
        press_op();
        check("op_in1", ALU_in1, 16'd12);
        check("op_disp_zero", display_output, 16'd0);
        enter_num(34);
        check("second_in2", ALU_in2, 16'd34);
        check("second_disp", display_output, 16'd34);
        finish_calc(16'd12, 16'd34, 4'd0);

        equal_input = 1'b1;
        step();
        equal_input = 1'b0;
        step();
        check("eq_ignored_done", {15'b0, complete}, 16'd1);
        check("disp_done_hold", display_output, 16'd46);

        // Chain from DONE, then wrap the pointer.
        press_op();
        check("chain_in1", ALU_in1, 16'd46);
        check("chain_in2", ALU_in2, 16'd0);
        check("chain_complete", {15'b0, complete}, 16'd0);
        enter_num(1);
        finish_calc(16'd46, 16'd1, 4'd1);
        for (int i = 2; i <= 16; i++) begin
            press_op();
            enter_num(1);
            finish_calc(16'(45 + i), 16'd1, 4'(i % 16));
        end

        // Digit from DONE starts a fresh calculation.
        press(4'h7);
        check("done_digit_in1", ALU_in1, 16'd7);
        check("done_digit_in2", ALU_in2, 16'd0);
        check("done_digit_disp", display_output, 16'd7);
        check("done_digit_cmpl", {15'b0, complete}, 16'd0);

        // Operator beats a same-cycle key.
        keypad_input   = 4'h3;
        operator_input = 1'b1;
        step();
        keypad_input   = 4'h0;
        operator_input = 1'b0;
        step();
        check("prio_op_in1", ALU_in1, 16'd7);
        check("prio_op_disp", display_output, 16'd0);
        press_op();
        enter_num(2);
        check("op_ignored_second", ALU_in2, 16'd2);

        // Equals beats a same-cycle key; then reset in WAIT_ALU.
        keypad_input = 4'h5;
        equal_input  = 1'b1;
        step();
        keypad_input = 4'h0;
        equal_input  = 1'b0;
        check("prio_eq_start", {15'b0, start_calc}, 16'd1);
        check("prio_eq_in2", ALU_in2, 16'd2);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_all_zero("midreset");
        ALU_finish = 1'b1;
        ALU_out    = 16'd99;
        step();
        step();
        step();
        ALU_finish = 1'b0;
        ALU_out    = 16'h0;
        check("late_finish_we", {15'b0, we}, 16'd0);
        check("late_finish_cmpl", {15'b0, complete}, 16'd0);
        check("late_finish_disp", display_output, 16'd0);

        // Pointer was cleared by reset.
        enter_num(5);
        press_op();
        enter_num(6);
        finish_calc(16'd5, 16'd6, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
